// File: rtl/panda_mem_pkg.sv
// Shared types and helpers for the instruction/load-store ram arbiter.
package panda_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } mem_port_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN_IF = 2'd1,
        ST_OWN_LS = 2'd2
    } arb_state_e;

    localparam logic [3:0] WE_BYTE = 4'b0001;
    localparam logic [3:0] WE_HALF = 4'b0011;
    localparam logic [3:0] WE_WORD = 4'b1111;

    function automatic logic [3:0] size_to_we(input logic [1:0] size);
        logic [3:0] we;
        case (size)
            SZ_BYTE: we = WE_BYTE;
            SZ_HALF: we = WE_HALF;
            SZ_WORD: we = WE_WORD;
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

    // The ram only writes low-aligned lanes, so any store off a word boundary is refused.
    function automatic logic ls_illegal(input logic we, input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        return (size == 2'd3) || (we && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/ram_arb_fsm.sv
// Owner FSM with bounded burst and round-robin tie break; produces the comb. grants.
module ram_arb_fsm
    import panda_mem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rstn_i,
    input  logic if_req_i,
    input  logic ls_req_i,
    output logic if_gnt_o,
    output logic ls_gnt_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_port_e        rr_q, rr_d;
    logic             pick_if_s, pick_ls_s;

    // Grant selection and next owner/counter/round-robin state.
    always_comb begin
        pick_if_s = 1'b0;
        pick_ls_s = 1'b0;
        case (state_q)
            ST_OWN_IF: begin
                if (if_req_i && !(ls_req_i && (cnt_q >= CNT_MAX))) pick_if_s = 1'b1;
                else if (ls_req_i)                                 pick_ls_s = 1'b1;
                else                                               pick_if_s = 1'b0;
            end
            ST_OWN_LS: begin
                if (ls_req_i && !(if_req_i && (cnt_q >= CNT_MAX))) pick_ls_s = 1'b1;
                else if (if_req_i)                                 pick_if_s = 1'b1;
                else                                               pick_ls_s = 1'b0;
            end
            default: begin
                // rr_q remembers the last owner; a tie goes to the other port.
                if (if_req_i && ls_req_i) begin
                    if (rr_q == PORT_IF) pick_ls_s = 1'b1;
                    else                 pick_if_s = 1'b1;
                end else begin
                    pick_if_s = if_req_i;
                    pick_ls_s = ls_req_i;
                end
            end
        endcase

        state_d = ST_IDLE;
        cnt_d   = '0;
        rr_d    = rr_q;
        if (pick_if_s) begin
            state_d = ST_OWN_IF;
            rr_d    = PORT_IF;
            if (state_q == ST_OWN_IF) cnt_d = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            else                      cnt_d = CNT_ONE;
        end else if (pick_ls_s) begin
            state_d = ST_OWN_LS;
            rr_d    = PORT_LS;
            if (state_q == ST_OWN_LS) cnt_d = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            else                      cnt_d = CNT_ONE;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Owner state registers.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rr_q    <= PORT_IF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    assign if_gnt_o = pick_if_s & rstn_i;
    assign ls_gnt_o = pick_ls_s & rstn_i;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port ram between instruction fetch and load/store, with
// registered one-cycle responses and rejection of stores the ram cannot perform.
module ram_arbiter
    import panda_mem_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rstn_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [1:0]        ls_size_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [31:0]       ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [31:0]       ls_rdata_o,
    output logic              ls_err_o,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_din_o,
    input  logic [31:0]       ram_dout_i
);

    logic              if_gnt_s, ls_gnt_s, ls_bad_s;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic              if_rvalid_q, ls_rvalid_q, ls_err_q;
    logic [31:0]       if_rdata_q, ls_rdata_q;

    ram_arb_fsm #(.MAX_BURST(MAX_BURST)) u_fsm (
        .clk      (clk),
        .rstn_i   (rstn_i),
        .if_req_i (if_req_i),
        .ls_req_i (ls_req_i),
        .if_gnt_o (if_gnt_s),
        .ls_gnt_o (ls_gnt_s)
    );

    assign ls_bad_s = ls_illegal(ls_we_i, ls_size_i, ls_addr_i[1:0]);

    // Ram port mux; address and data hold their last value when nobody is granted.
    always_comb begin
        addr_d   = addr_q;
        din_d    = din_q;
        ram_en_o = 1'b0;
        ram_we_o = 4'b0000;
        if (if_gnt_s) begin
            addr_d   = if_addr_i;
            ram_en_o = 1'b1;
        end else if (ls_gnt_s) begin
            addr_d   = ls_addr_i;
            din_d    = ls_wdata_i;
            ram_en_o = !ls_bad_s;
            if (ls_we_i && !ls_bad_s) ram_we_o = size_to_we(ls_size_i);
            else                      ram_we_o = 4'b0000;
        end else begin
            ram_en_o = 1'b0;
        end
    end

    assign ram_addr_o = addr_d;
    assign ram_din_o  = din_d;

    // Response registers: data captured in the grant cycle, valid one cycle later.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q      <= '0;
            din_q       <= 32'h0000_0000;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'h0000_0000;
            ls_rvalid_q <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= 32'h0000_0000;
        end else begin
            addr_q      <= addr_d;
            din_q       <= din_d;
            if_rvalid_q <= if_gnt_s;
            ls_rvalid_q <= ls_gnt_s;
            ls_err_q    <= ls_gnt_s && ls_bad_s;
            if (if_gnt_s) if_rdata_q <= ram_dout_i;
            else          if_rdata_q <= if_rdata_q;
            if (ls_gnt_s) ls_rdata_q <= (ls_we_i || ls_bad_s) ? 32'h0000_0000 : ram_dout_i;
            else          ls_rdata_q <= ls_rdata_q;
        end
    end

    assign if_gnt_o    = if_gnt_s;
    assign ls_gnt_o    = ls_gnt_s;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rvalid_o = ls_rvalid_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign ls_err_o    = ls_err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a byte-level memory reference.
module tb_ram_arbiter;
    import panda_mem_pkg::*;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] if_addr = 32'h0, ls_addr = 32'h0, ls_wdata = 32'h0;
    logic        if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, ls_err_o, ram_en_o;
    logic [31:0] if_rdata_o, ls_rdata_o, ram_addr_o, ram_din_o, ram_dout;
    logic [3:0]  ram_we_o;

    always #5 clk = ~clk;

    ram_arbiter #(.MAX_BURST(MB), .ADDR_W(32)) dut (
        .clk(clk), .rstn_i(rstn_i),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_size_i(ls_size), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
        .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_din_o(ram_din_o), .ram_dout_i(ram_dout)
    );

    // Ram model: combinational read, byte-lane synchronous write.
    logic [31:0] ram [0:63];
    logic [31:0] ref_mem [0:63];
    assign ram_dout = ram[ram_addr_o[7:2]];
    always @(posedge clk)
        if (ram_en_o)
            for (int b = 0; b < 4; b++)
                if (ram_we_o[b]) ram[ram_addr_o[7:2]][8*b +: 8] <= ram_din_o[8*b +: 8];

    typedef struct packed { logic [31:0] data; logic err; int cyc; } exp_t;
    exp_t if_q[$];
    exp_t ls_q[$];
    int   glog[$];
    int   total = 0, bad = 0, cyc = 0, if_wait = 0, ls_wait = 0;
    logic sb_en = 1'b0, log_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    // Grant observer: checks arbitration rules and ram drive, pushes expected responses.
    always @(negedge clk) begin : obs
        logic       bad_s;
        logic [3:0] we_s;
        exp_t       e;
        int         wi;
        if (sb_en && rstn_i) begin
            chk_b("gnt_onehot", if_gnt_o & ls_gnt_o, 1'b0);
            if (if_gnt_o) chk_b("if_gnt_without_req", if_req, 1'b1);
            if (ls_gnt_o) chk_b("ls_gnt_without_req", ls_req, 1'b1);
            chk_b("work_conserving", if_gnt_o | ls_gnt_o, if_req | ls_req);
            if (if_gnt_o) begin
                chk_b("if_starvation", if_wait <= MB, 1'b1);
                if_wait = 0;
            end else if (if_req) if_wait++;
            if (ls_gnt_o) begin
                chk_b("ls_starvation", ls_wait <= MB, 1'b1);
                ls_wait = 0;
            end else if (ls_req) ls_wait++;

            if (if_gnt_o) begin
                chk_b("if_ram_en", ram_en_o, 1'b1);
                chk("if_ram_we", 32'(ram_we_o), 32'h0);
                chk("if_ram_addr", ram_addr_o, if_addr);
                e.data = ref_mem[if_addr[7:2]];
                e.err  = 1'b0;
                e.cyc  = cyc;
                if_q.push_back(e);
                if (log_en) glog.push_back(0);
            end else if (ls_gnt_o) begin
                wi    = int'(ls_addr[7:2]);
                bad_s = (ls_size == 2'd3) || (ls_we && ls_addr[1:0] != 2'b00);
                we_s  = 4'b0000;
                if (ls_we && !bad_s) we_s = (ls_size == 2'd0) ? 4'b0001 :
                                            (ls_size == 2'd1) ? 4'b0011 : 4'b1111;
                chk_b("ls_ram_en", ram_en_o, !bad_s);
                chk("ls_ram_we", 32'(ram_we_o), 32'(we_s));
                if (!bad_s) chk("ls_ram_addr", ram_addr_o, ls_addr);
                if (ls_we && !bad_s) chk("ls_ram_din", ram_din_o, ls_wdata);
                e.data = (ls_we || bad_s) ? 32'h0 : ref_mem[wi];
                e.err  = bad_s;
                e.cyc  = cyc;
                ls_q.push_back(e);
                if (log_en) glog.push_back(1);
                if (ls_we && !bad_s) begin
                    if (ls_size == 2'd0)      ref_mem[wi] = {ref_mem[wi][31:8], ls_wdata[7:0]};
                    else if (ls_size == 2'd1) ref_mem[wi] = {ref_mem[wi][31:16], ls_wdata[15:0]};
                    else                      ref_mem[wi] = ls_wdata;
                end
            end else begin
                chk_b("idle_ram_en", ram_en_o, 1'b0);
                chk("idle_ram_we", 32'(ram_we_o), 32'h0);
            end
        end else begin
            if_wait = 0;
            ls_wait = 0;
        end
    end

    // Response monitor: every expected response must appear exactly one cycle after its grant.
    always @(negedge clk) begin : mon
        exp_t e;
        if (sb_en && rstn_i) begin
            if (if_q.size() > 0 && if_q[0].cyc == cyc - 1) begin
                e = if_q.pop_front();
                chk_b("if_rvalid", if_rvalid_o, 1'b1);
                chk("if_rdata", if_rdata_o, e.data);
            end else chk_b("if_rvalid_spurious", if_rvalid_o, 1'b0);
            if (ls_q.size() > 0 && ls_q[0].cyc == cyc - 1) begin
                e = ls_q.pop_front();
                chk_b("ls_rvalid", ls_rvalid_o, 1'b1);
                chk("ls_rdata", ls_rdata_o, e.data);
                chk_b("ls_err", ls_err_o, e.err);
            end else chk_b("ls_rvalid_spurious", ls_rvalid_o, 1'b0);
        end
    end

    task automatic if_txn(input logic [31:0] a, output int n);
        logic g;
        n = 0;
        if_req = 1'b1; if_addr = a;
        do begin
            @(negedge clk); g = if_gnt_o;
            @(posedge clk); #1; n++;
        end while (!g && n < 50);
        chk_b("if_gnt_timeout", g, 1'b1);
        if_req = 1'b0;
    endtask

    task automatic ls_txn(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, output int n);
        logic g;
        n = 0;
        ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
        do begin
            @(negedge clk); g = ls_gnt_o;
            @(posedge clk); #1; n++;
        end while (!g && n < 50);
        chk_b("ls_gnt_timeout", g, 1'b1);
        ls_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((if_q.size() != 0 || ls_q.size() != 0) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk_b("drain", (if_q.size() == 0) && (ls_q.size() == 0), 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) begin
            ram[i]     = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        end
        if_req = 1'b1; ls_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_b("rst_if_gnt", if_gnt_o, 1'b0);
        chk_b("rst_ls_gnt", ls_gnt_o, 1'b0);
        chk_b("rst_if_rvalid", if_rvalid_o, 1'b0);
        chk_b("rst_ls_rvalid", ls_rvalid_o, 1'b0);
        chk_b("rst_ls_err", ls_err_o, 1'b0);
        chk("rst_if_rdata", if_rdata_o, 32'h0);
        chk("rst_ls_rdata", ls_rdata_o, 32'h0);
        chk_b("rst_ram_en", ram_en_o, 1'b0);
        chk("rst_ram_we", 32'(ram_we_o), 32'h0);
        if_req = 1'b0; ls_req = 1'b0;
        rstn_i = 1'b1; sb_en = 1'b1;
        @(posedge clk); #1;

        // Both ports held from reset: bursts of MB alternate, LS first.
        log_en = 1'b1;
        fork
            begin int k; for (int i = 0; i < 8; i++) ls_txn(1'b0, 2'd2, 32'(i * 4), 32'h0, k); end
            begin int k; for (int i = 0; i < 8; i++) if_txn(32'h40 + 32'(i * 4), k); end
        join
        log_en = 1'b0;
        chk("burst_log_len", 32'(glog.size()), 32'd16);
        for (int i = 0; i < glog.size() && i < 16; i++)
            chk("burst_order", 32'(glog[i]), ((i / MB) % 2 == 0) ? 32'd1 : 32'd0);
        drain();

        if_txn(32'h10, n);
        chk("t1_gnt_latency", 32'(n), 32'd1);
        chk_b("t1_rvalid", if_rvalid_o, 1'b1);
        chk("t1_rdata", if_rdata_o, 32'h1404_0404);

        ls_txn(1'b1, 2'd1, 32'h20, 32'hDEAD_BEEF, n);
        ls_txn(1'b0, 2'd2, 32'h20, 32'h0, n);
        chk("t3_half_store", ls_rdata_o, 32'h1808_BEEF);
        ls_txn(1'b1, 2'd2, 32'h22, 32'h1234_5678, n);
        chk_b("t4_rvalid", ls_rvalid_o, 1'b1);
        chk_b("t4_err", ls_err_o, 1'b1);
        chk("t4_rdata", ls_rdata_o, 32'h0);
        ls_txn(1'b0, 2'd2, 32'h20, 32'h0, n);
        chk("t4_mem_unchanged", ls_rdata_o, 32'h1808_BEEF);
        drain();

        fork
            begin int k; for (int i = 0; i < 20; i++) ls_txn(1'b0, 2'd2, 32'h80, 32'h0, k); end
            begin
                int k;
                repeat (3) begin @(posedge clk); #1; end
                if_txn(32'h30, k);
                chk_b("t5_if_bound", k <= MB + 1, 1'b1);
            end
        join
        drain();

        fork
            begin
                int k;
                logic [31:0] a;
                logic        w;
                for (int i = 0; i < 150; i++) begin
                    w = 1'($urandom_range(0, 1));
                    a = 32'($urandom_range(0, 255));
                    if (!w || $urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
                    ls_txn(w, 2'($urandom_range(0, 3)), a, $urandom, k);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                int k;
                for (int i = 0; i < 150; i++) begin
                    if_txn(32'($urandom_range(0, 255)) & 32'hFFFF_FFFC, k);
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
        join
        drain();

        // Reset in the cycle after a grant drops the pending response.
        sb_en = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        chk_b("t6_gnt", if_gnt_o, 1'b1);
        rstn_i = 1'b0;
        @(posedge clk); #1;
        chk_b("t6_if_rvalid", if_rvalid_o, 1'b0);
        chk_b("t6_if_gnt", if_gnt_o, 1'b0);
        chk_b("t6_ram_en", ram_en_o, 1'b0);
        chk("t6_if_rdata", if_rdata_o, 32'h0);
        if_req = 1'b0;
        @(posedge clk); #1;
        rstn_i = 1'b1;
        @(posedge clk); #1;
        chk_b("t6_no_late_rvalid", if_rvalid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
